// File: rtl/cpsd_report_tx_if.sv
// Class inputs, overrun control and UART status/line of the CPSD report transmitter.
interface cpsd_report_tx_if;
  logic normal;
  logic AF;
  logic VF;
  logic clr_overrun;
  logic tx;
  logic busy;
  logic overrun;

  modport master (
    output normal, AF, VF, clr_overrun,
    input  tx, busy, overrun
  );

  modport slave (
    input  normal, AF, VF, clr_overrun,
    output tx, busy, overrun
  );
endinterface

// File: rtl/cpsd_report_tx.sv
// Turns class changes of the CPSD classifier into tagged report bytes and sends
// them as 8N1 UART frames through a one-entry pending buffer.
module cpsd_report_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SEQ_WIDTH    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  cpsd_report_tx_if.slave  bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [2:0]           code_q;
  logic [2:0]           last_q;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic [7:0]           pend_q;
  logic                 pend_valid_q;
  logic                 overrun_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_q;
  logic [CW-1:0]        cnt_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 evt;
  logic                 multi;
  logic [7:0]           rpt_byte;
  logic                 consume;
  logic                 cnt_last;

  always_comb begin
    evt      = (code_q != last_q) && (code_q != 3'b000);
    multi    = (code_q[2] & code_q[1]) | (code_q[2] & code_q[0]) | (code_q[1] & code_q[0]);
    rpt_byte = 8'({seq_q, multi, code_q});
    consume  = (state_q == IDLE) && pend_valid_q;
    cnt_last = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      code_q       <= '0;
      last_q       <= '0;
      seq_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      shift_q      <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else if (en) begin
      code_q <= {bus.VF, bus.AF, bus.normal};
      last_q <= code_q;

      // An event landing on the consume edge refills pending while the old
      // byte moves to the shifter, so it is not an overrun.
      if (evt) begin
        seq_q        <= seq_q + SEQ_WIDTH'(1);
        pend_q       <= rpt_byte;
        pend_valid_q <= 1'b1;
      end else if (consume) begin
        pend_valid_q <= 1'b0;
      end

      if (evt && pend_valid_q && !consume) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (pend_valid_q) begin
            shift_q <= pend_q;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cpsd_report_tx.sv
// Directed bench for cpsd_report_tx with CLKS_PER_BIT=4: latency, frame bits,
// sequence tags, overrun, stall and asynchronous reset.
module tb_cpsd_report_tx;

  logic clk;
  logic rstn;
  logic en;
  int   total;
  int   bad;

  cpsd_report_tx_if bus ();

  cpsd_report_tx #(.CLKS_PER_BIT(4), .SEQ_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line level for bit slot k of a frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] c);
    bus.VF     = c[2];
    bus.AF     = c[1];
    bus.normal = c[0];
  endtask

  task automatic do_reset();
    drive(3'b000);
    bus.clr_overrun = 1'b0;
    en   = 1'b1;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  // Waits (bounded) for a start bit, then samples each bit mid-slot.
  // Returns at 38 clocks after the falling edge, inside the stop bit.
  task automatic rx_byte(output logic [7:0] d, output logic sb, output logic pb,
                         output logic to);
    int n;
    n  = 0;
    to = 1'b0;
    d  = '0;
    sb = 1'b1;
    pb = 1'b0;
    while (bus.tx !== 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    if (bus.tx !== 1'b0) begin
      to = 1'b1;
      return;
    end
    tick(2);
    sb = bus.tx;
    for (int i = 0; i < 8; i++) begin
      tick(4);
      d[i] = bus.tx;
    end
    tick(4);
    pb = bus.tx;
  endtask

  task automatic test_reset();
    drive(3'b000);
    bus.clr_overrun = 1'b0;
    en   = 1'b1;
    rstn = 1'b0;
    tick(2);
    total++;
    if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    rstn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      total++;
      if ({bus.tx, bus.busy, bus.overrun} !== 3'b100) begin
        bad++;
        $display("FAIL idle_lines cyc=%0d got tx,busy,ovr=%b exp=100", c,
                 {bus.tx, bus.busy, bus.overrun});
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(3'b001);
    tick(2);
    total++;
    if (bus.tx !== 1'b1) begin bad++; $display("FAIL latency_e1_tx got=%b exp=1", bus.tx); end
    tick(1);
    for (int off = 0; off < 40; off++) begin
      if (off > 0) tick(1);
      total++;
      if (bus.tx !== frame_bit(8'h01, off / 4) || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL single_frame off=%0d got tx=%b busy=%b exp tx=%b busy=1", off,
                 bus.tx, bus.busy, frame_bit(8'h01, off / 4));
      end
    end
    tick(1);
    total++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      bad++;
      $display("FAIL single_end got tx=%b busy=%b exp tx=1 busy=0", bus.tx, bus.busy);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] d;
    logic sb, pb, to;
    logic [7:0] exp_b [3];
    logic [2:0] codes [3];
    exp_b = '{8'h01, 8'h12, 8'h22};
    codes = '{3'b001, 3'b010, 3'b010};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        drive(3'b000);
        tick(20);
      end
      drive(codes[i]);
      rx_byte(d, sb, pb, to);
      total++;
      if (to || sb !== 1'b0 || pb !== 1'b1 || d !== exp_b[i]) begin
        bad++;
        $display("FAIL seq_byte%0d got=%h start=%b stop=%b timeout=%b exp=%h", i, d, sb, pb,
                 to, exp_b[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d, e;
    logic sb, pb, to;
    logic [2:0] c;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      c = (i % 2 == 0) ? 3'b001 : 3'b010;
      e = {4'(i % 16), 1'b0, c};
      drive(c);
      rx_byte(d, sb, pb, to);
      total++;
      if (to || sb !== 1'b0 || pb !== 1'b1 || d !== e) begin
        bad++;
        $display("FAIL wrap_byte%0d got=%h timeout=%b exp=%h", i, d, to, e);
      end
    end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_multi();
    logic [7:0] d;
    logic sb, pb, to;
    do_reset();
    drive(3'b110);
    rx_byte(d, sb, pb, to);
    total++;
    if (to || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h0E) begin
      bad++;
      $display("FAIL multi_byte got=%h timeout=%b exp=0e", d, to);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic sb, pb, to;
    do_reset();
    drive(3'b001);
    tick(2);
    drive(3'b010);
    tick(1);
    total++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ovr_frame1_start got tx=%b busy=%b exp tx=0 busy=1", bus.tx, bus.busy);
    end
    tick(1);
    drive(3'b100);
    tick(1);
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", bus.overrun); end
    tick(1);
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    for (int off = 4; off < 40; off++) begin
      tick(1);
      total++;
      if (bus.tx !== frame_bit(8'h01, off / 4)) begin
        bad++;
        $display("FAIL ovr_frame1 off=%0d got=%b exp=%b", off, bus.tx, frame_bit(8'h01, off / 4));
      end
    end
    tick(1);
    total++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ovr_gap_idle got tx=%b busy=%b exp tx=1 busy=0", bus.tx, bus.busy);
    end
    tick(1);
    total++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ovr_frame2_start got tx=%b busy=%b exp tx=0 busy=1", bus.tx, bus.busy);
    end
    rx_byte(d, sb, pb, to);
    total++;
    if (to || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h24) begin
      bad++;
      $display("FAIL ovr_frame2_byte got=%h timeout=%b exp=24", d, to);
    end
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    bus.clr_overrun = 1'b1;
    tick(1);
    bus.clr_overrun = 1'b0;
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic sb, pb, to;
    do_reset();
    drive(3'b001);
    tick(3);
    tick(4);
    drive(3'b010);
    tick(35);
    drive(3'b100);
    rx_byte(d, sb, pb, to);
    total++;
    if (to || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h12) begin
      bad++;
      $display("FAIL b2b_frame2 got=%h timeout=%b exp=12", d, to);
    end
    tick(2);
    total++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got tx=%b busy=%b exp tx=1 busy=0", bus.tx, bus.busy);
    end
    tick(1);
    total++;
    if (bus.tx !== 1'b0) begin bad++; $display("FAIL b2b_frame3_start got=%b exp=0", bus.tx); end
    rx_byte(d, sb, pb, to);
    total++;
    if (to || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h24) begin
      bad++;
      $display("FAIL b2b_frame3 got=%h timeout=%b exp=24", d, to);
    end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_en_stall();
    int eff;
    logic ex_tx, ex_busy;
    do_reset();
    drive(3'b110);
    tick(3);
    for (int off = 0; off <= 50; off++) begin
      if (off > 0) tick(1);
      eff     = (off <= 10) ? off : (off <= 20) ? 10 : off - 10;
      ex_tx   = (eff < 40) ? frame_bit(8'h0E, eff / 4) : 1'b1;
      ex_busy = (eff < 40);
      total++;
      if (bus.tx !== ex_tx || bus.busy !== ex_busy) begin
        bad++;
        $display("FAIL stall off=%0d got tx=%b busy=%b exp tx=%b busy=%b", off, bus.tx,
                 bus.busy, ex_tx, ex_busy);
      end
      if (off == 10) en = 1'b0;
      if (off == 20) en = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic sb, pb, to;
    drive(3'b010);
    tick(3);
    tick(13);
    total++;
    if (bus.tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx got=%b exp=0", bus.tx); end
    #2;
    rstn = 1'b0;
    drive(3'b000);
    #1;
    total++;
    if ({bus.tx, bus.busy, bus.overrun} !== 3'b100) begin
      bad++;
      $display("FAIL mid_async got tx,busy,ovr=%b exp=100", {bus.tx, bus.busy, bus.overrun});
    end
    tick(2);
    rstn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      total++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_resume cyc=%0d got tx=%b busy=%b exp tx=1 busy=0", c, bus.tx,
                 bus.busy);
      end
    end
    drive(3'b001);
    rx_byte(d, sb, pb, to);
    total++;
    if (to || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h01) begin
      bad++;
      $display("FAIL mid_seq_restart got=%h timeout=%b exp=01", d, to);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    en    = 1'b1;
    drive(3'b000);
    bus.clr_overrun = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_wrap();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_en_stall();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpsd_report_tx.md
Name: cpsd_report_tx

Overview:
Consumer end of the CPSD classifier outputs. It watches the one-hot rhythm class {VF, AF, normal}. On every change to a non-zero class it builds a tagged report byte. It buffers the byte in a one-entry pending register and serialises it as an 8N1 UART frame on a single line to the host/telemetry link. It sits directly after the thresholding stage of the detector top and shares its clk/rstn/en.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535; counter width is clog2(CLKS_PER_BIT).
SEQ_WIDTH, 4, width of the wrapping report sequence tag; fixed at 4 so the byte is exactly 8 bits.

Ports:
clk  input  1  system clock; all state on rising edge.
rstn  input  1  asynchronous active-low reset; one clock domain, no other clocks.
en  input  1  global enable; when low, all state is frozen.
normal  input  1  class output from thresholding.
AF  input  1  class output from thresholding.
VF  input  1  class output from thresholding.
clr_overrun  input  1  synchronous clear of the overrun flag (needs en=1).
tx  output  1  UART serial line; idle high.
busy  output  1  high while a frame is on the line.
overrun  output  1  sticky flag: a pending report was overwritten before it was sent.

Behaviour:
- Reset (rstn=0, async): tx=1, busy=0, overrun=0, seq=0, code_q=000, last_code=000, pending_valid=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- en=0: no register updates. tx holds its level, so the current bit is stretched. Inputs are not sampled.
- Input stage: code_q <= {VF,AF,normal} every en cycle. last_code <= code_q every en cycle, including 000.
- Event: (code_q != last_code) && (code_q != 000). Returning to the same class after a 000 gap is a new event.
- Report byte: {seq[3:0], multi, VF, AF, normal} taken from code_q. multi=1 when more than one class bit is set; the byte is still sent. seq is the value before the increment.
- On each event seq increments, wrapping 15 to 0.
- Pending register: an event writes the byte and sets pending_valid on the next edge.
  - If pending_valid is already 1 and is not being consumed that cycle: overwrite it, set overrun=1. seq still increments.
  - Event in the same cycle the FSM consumes pending: the old byte goes to the shifter, the new byte goes to pending, no overrun.
- Overrun set and clr_overrun in the same cycle: set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If pending_valid, load shifter, clear pending_valid, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 exactly in START/DATA/STOP; registered with the state.
- Frame length is 10*CLKS_PER_BIT clocks. Back-to-back frames have exactly 1 idle clock (IDLE state) between STOP end and the next START.
- Latency: class change sampled into code_q at edge E0; pending written at E1; START entered and tx falls at E2.
- tx is driven from a register (glitch-free).

Test Plan:
- Reset and idle: rstn low, then high, inputs 000 for 100 clocks -> tx=1, busy=0, overrun=0 throughout.
- Single report (CLKS_PER_BIT=4): normal rises at E0 -> tx falls at E2. Bits are 0,1,0,0,0,0,0,0,0,1 (start, byte 0x01 LSB first, stop), 4 clocks each. busy is high for 40 clocks.
- Sequence and class: normal → AF → 000 → AF, each held 60 clocks -> bytes 0x01, 0x12, 0x22. Wrap test: 17 alternating events, the 17th byte has seq=0.
- Multi-class: {VF,AF,normal}=110 -> byte 0x0E (seq=0, multi=1, code 110).
- Overrun: three events 2 clocks apart while frame 1 is transmitting.
  - Frame 1 carries event 1.
  - Event 2 is overwritten by event 3, and overrun=1.
  - Frame 2 carries event 3 with seq=2, starting after 1 idle clock.
  - clr_overrun pulse -> overrun=0.
- en and reset mid-frame: en low 10 clocks during DATA -> that bit is stretched by 10, frame otherwise intact. rstn low mid-DATA -> tx=1 immediately, no partial frame resumes, seq=0.
